spi_frame_receiver: RTL

//  Front end of the SPI register path: synchronises raw SCLK/COPI/nCS pins into clk,

---
 rtl/spi_rx_pkg.sv | 24 ++
 rtl/spi_frame_receiver_if.sv | 24 ++
 rtl/spi_rx_sync.sv | 36 +++
 rtl/spi_frame_receiver.sv | 127 ++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and frame layout for the SPI write-frame receiver.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } rx_state_t;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;

    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVERRUN = CNT_W'(17);

    // Bit counter parks at the overrun marker so any long frame still reads as bad.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_OVERRUN) ? CNT_OVERRUN : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_frame_receiver_if.sv
// SPI pin bundle plus the committed-write bus towards the register bank.
interface spi_frame_receiver_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              copi;
    logic              ncs;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_err;
    logic              busy;

    modport master (
        output sclk, copi, ncs,
        input  wr_valid, wr_addr, wr_data, frame_err, busy
    );

    modport slave (
        input  sclk, copi, ncs,
        output wr_valid, wr_addr, wr_data, frame_err, busy
    );
endinterface

// File: rtl/spi_rx_sync.sv
// Multi-flop pin synchroniser with rise/fall detection on the synchronised level.
module spi_rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;
    logic [STAGES:0]   fill_reg;
    logic              primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_reg <= {STAGES{RST_VAL}};
            prev_reg  <= RST_VAL;
            fill_reg  <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], din};
            prev_reg  <= chain_reg[STAGES-1];
            fill_reg  <= {fill_reg[STAGES-1:0], 1'b1};
        end
    end

    // Edges are only trusted once both dout and prev_reg hold real pin samples,
    // so a pin already at its active level at reset release is not seen as an edge.
    assign primed = fill_reg[STAGES];
    assign dout   = chain_reg[STAGES-1];
    assign rise   = primed &  dout & ~prev_reg;
    assign fall   = primed & ~dout &  prev_reg;
endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 16-bit write-frame receiver; SPI_RX_ERR_COUNT_EN adds a saturating
// err_count output of frame_err pulses.
module spi_frame_receiver
    import spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int MAX_ADDR    = 4
) (
    input  logic                clk,
    input  logic                rst,
    spi_frame_receiver_if.slave bus
`ifdef SPI_RX_ERR_COUNT_EN
    ,
    output logic [7:0]          err_count
`endif
);
    localparam logic [ADDR_W-1:0] MAX_ADDR_V = ADDR_W'(MAX_ADDR);

    logic sclk_rise, ncs_rise, ncs_fall, copi_s;
    logic sclk_unused_lvl, sclk_unused_fall, copi_unused_rise, copi_unused_fall;
    logic ncs_unused_lvl;

    spi_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(bus.sclk),
        .dout(sclk_unused_lvl), .rise(sclk_rise), .fall(sclk_unused_fall)
    );
    spi_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din(bus.copi),
        .dout(copi_s), .rise(copi_unused_rise), .fall(copi_unused_fall)
    );
    spi_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .din(bus.ncs),
        .dout(ncs_unused_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    rx_state_t               state_reg, state_next;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    wr_valid_reg, wr_valid_next;
    logic [ADDR_W-1:0]       wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0]       wr_data_reg, wr_data_next;
    logic                    frame_err_reg, frame_err_next;
    logic [ADDR_W-1:0]       frame_addr;

    assign frame_addr = shift_reg[ADDR_MSB:ADDR_LSB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            cnt_reg       <= '0;
            wr_valid_reg  <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            cnt_reg       <= cnt_next;
            wr_valid_reg  <= wr_valid_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        cnt_next       = cnt_reg;
        wr_valid_next  = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ncs_fall) begin
                    state_next = SHIFT;
                    shift_next = '0;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                // End of frame takes priority over a coincident SCLK edge.
                if (ncs_rise) begin
                    state_next = COMMIT;
                end else if (sclk_rise) begin
                    shift_next = {shift_reg[FRAME_BITS-2:0], copi_s};
                    cnt_next   = cnt_inc(cnt_reg);
                end
            end
            COMMIT: begin
                state_next = IDLE;
                if (cnt_reg != CNT_FULL) begin
                    frame_err_next = 1'b1;
                end else if (shift_reg[RW_BIT] && (frame_addr <= MAX_ADDR_V)) begin
                    wr_valid_next = 1'b1;
                    wr_addr_next  = frame_addr;
                    wr_data_next  = shift_reg[DATA_W-1:0];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.wr_valid  = wr_valid_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.wr_data   = wr_data_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = (state_reg == SHIFT);

`ifdef SPI_RX_ERR_COUNT_EN
    logic [7:0] err_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_reg <= '0;
        end else if (frame_err_next && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`endif
endmodule
